// File: rtl/cpc_ram_pkg.sv
// Shared types and constants for the CPC RAM bank controller and its mapper.
// States, mode encodings and IO-decode match values live here so boards stay consistent.
package cpc_ram_pkg;

  typedef enum logic [1:0] {
    IO_IDLE,
    IO_HIT,
    IO_WAIT
  } io_state_t;

  typedef enum logic {
    M_IDLE,
    M_ACT
  } mem_state_t;

  // Mode field (low three bits of the bank-select byte)
  localparam logic [2:0] MODE_NONE     = 3'd0;
  localparam logic [2:0] MODE_B3       = 3'd1;
  localparam logic [2:0] MODE_ALL      = 3'd2;
  localparam logic [2:0] MODE_B3_REMAP = 3'd3;
  localparam logic [2:0] MODE_B1_0     = 3'd4;
  localparam logic [2:0] MODE_B1_1     = 3'd5;
  localparam logic [2:0] MODE_B1_2     = 3'd6;
  localparam logic [2:0] MODE_B1_3     = 3'd7;

  localparam logic [1:0] IO_DATA_PREFIX = 2'b11;
  localparam logic       IO_A15         = 1'b0;

  localparam int BANK_BITS_MIN = 3;
  localparam int BANK_BITS_MAX = 6;

  function automatic bit bank_bits_legal(input int bits);
    return (bits >= BANK_BITS_MIN) && (bits <= BANK_BITS_MAX);
  endfunction

endpackage

// File: rtl/cpc_bank_map.sv
// Pure combinational mapper: {mode, bank, 16K block} -> expansion hit and SRAM upper address.
// Mode 3 block 1 is an internal remap, so it reports no expansion hit.
module cpc_bank_map
  import cpc_ram_pkg::*;
#(
  parameter int BANK_BITS = 3
) (
  input  logic [2:0]           mode,
  input  logic [BANK_BITS-1:0] bank,
  input  logic [1:0]           blk,
  output logic                 hit,
  output logic [BANK_BITS+1:0] ramadrhi
);

  logic [1:0] exp_blk;

  always_comb begin
    hit     = 1'b0;
    exp_blk = blk;
    case (mode)
      MODE_NONE:              hit = 1'b0;
      MODE_B3, MODE_B3_REMAP: hit = (blk == 2'd3);
      MODE_ALL:               hit = 1'b1;
      default: begin
        // Modes 4..7 window the selected expansion block into CPU block 1
        hit     = (blk == 2'd1);
        exp_blk = mode[1:0];
      end
    endcase
  end

  assign ramadrhi = {bank, exp_blk};

endmodule

// File: rtl/cpc_ram_bank_ctrl.sv
// CPC RAM expansion controller: IO bank-select decode, Z80 memory-cycle tracking, SRAM control.
// Optional macro CPC_EXT_BANK_EN enables the 4M-style upper bank bits taken from inverted A10..A8.
module cpc_ram_bank_ctrl
  import cpc_ram_pkg::*;
#(
  parameter int BANK_BITS = 3,
  parameter int ADR_HI_W  = BANK_BITS + 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iorq_b,
  input  logic                 mreq_b,
  input  logic                 rfsh_b,
  input  logic                 wr_b,
  input  logic                 rd_b,
  input  logic [7:0]           adr_hi,
  input  logic [7:0]           data,
  output logic [ADR_HI_W-1:0]  ramadrhi,
  output logic                 ramcs_b,
  output logic                 ramwe_b,
  output logic                 ramoe_b,
  output logic                 ramdis,
  output logic [BANK_BITS+2:0] cfg_q
);

  localparam int CFG_W = BANK_BITS + 3;
  localparam int UPPER = BANK_BITS - 3;

  if (!bank_bits_legal(BANK_BITS)) begin : g_bad_bank_bits
    $error("cpc_ram_bank_ctrl: BANK_BITS must be in 3..6");
  end

  io_state_t  io_state, io_next;
  mem_state_t mem_state, mem_next;

  logic                 io_match, io_capture, mem_enter, commit, active;
  logic                 pending;
  logic [CFG_W-1:0]     pending_cfg, cap_cfg;
  logic [BANK_BITS-1:0] cap_bank;
  logic                 a15_q, a14_q;
  logic                 map_hit;
  logic [ADR_HI_W-1:0]  map_adr;
  logic                 unused_adr;

  assign unused_adr = ^adr_hi[5:0];

`ifdef CPC_EXT_BANK_EN
  localparam bit NEED_A13_LOW = (BANK_BITS < 6);
  assign io_match = !iorq_b && !wr_b && (adr_hi[7] == IO_A15) &&
                    (data[7:6] == IO_DATA_PREFIX) && !(NEED_A13_LOW && adr_hi[5]);
`else
  assign io_match = !iorq_b && !wr_b && (adr_hi[7] == IO_A15) &&
                    (data[7:6] == IO_DATA_PREFIX);
`endif

  assign cap_bank[2:0] = data[5:3];
  if (UPPER > 0) begin : g_upper_bank
`ifdef CPC_EXT_BANK_EN
    assign cap_bank[BANK_BITS-1:3] = ~adr_hi[UPPER-1:0];
`else
    assign cap_bank[BANK_BITS-1:3] = '0;
`endif
  end
  assign cap_cfg = {cap_bank, data[2:0]};

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      io_state  <= IO_IDLE;
      mem_state <= M_IDLE;
    end else begin
      io_state  <= io_next;
      mem_state <= mem_next;
    end
  end

  // Next-state logic
  always_comb begin
    io_next = io_state;
    case (io_state)
      IO_IDLE: if (io_match) io_next = IO_HIT;
      IO_HIT:  io_next = IO_WAIT;
      IO_WAIT: if (iorq_b) io_next = IO_IDLE;
      default: io_next = IO_IDLE;
    endcase

    mem_next = mem_state;
    case (mem_state)
      M_IDLE:  if (!mreq_b && rfsh_b) mem_next = M_ACT;
      M_ACT:   if (mreq_b) mem_next = M_IDLE;
      default: mem_next = M_IDLE;
    endcase
  end

  // FSM outputs: capture/latch/commit strobes and the active-mapped condition
  always_comb begin
    io_capture = (io_state == IO_IDLE) && io_match;
    mem_enter  = (mem_state == M_IDLE) && !mreq_b && rfsh_b;
    commit     = (mem_state == M_IDLE) && pending;
    active     = (mem_state == M_ACT) && !mreq_b && map_hit;
  end

  cpc_bank_map #(
    .BANK_BITS(BANK_BITS)
  ) u_map (
    .mode     (cfg_q[2:0]),
    .bank     (cfg_q[CFG_W-1:3]),
    .blk      ({a15_q, a14_q}),
    .hit      (map_hit),
    .ramadrhi (map_adr)
  );

  // Capture follows commit so a hit on the commit edge stays pending (last write wins)
  always_ff @(posedge clk) begin
    if (reset) begin
      pending     <= 1'b0;
      pending_cfg <= '0;
      cfg_q       <= '0;
      a15_q       <= 1'b0;
      a14_q       <= 1'b0;
      ramadrhi    <= '0;
      ramcs_b     <= 1'b1;
      ramwe_b     <= 1'b1;
      ramoe_b     <= 1'b1;
      ramdis      <= 1'b0;
    end else begin
      if (commit) begin
        cfg_q   <= pending_cfg;
        pending <= 1'b0;
      end
      if (io_capture) begin
        pending_cfg <= cap_cfg;
        pending     <= 1'b1;
      end
      if (mem_enter) begin
        a15_q <= adr_hi[7];
        a14_q <= adr_hi[6];
      end
      ramcs_b  <= !active;
      ramdis   <= active;
      ramadrhi <= active ? map_adr : '0;
      ramwe_b  <= !(active && !wr_b);
      ramoe_b  <= !(active && !rd_b);
    end
  end

endmodule

// File: tb/tb_cpc_ram_bank_ctrl.sv
// Bench for cpc_ram_bank_ctrl (BANK_BITS=6): directed scenarios with literal expectations,
// then randomized bus traffic checked every cycle against a cycle-level behavioural model.
module tb_cpc_ram_bank_ctrl;

  localparam int BB = 6;
  localparam int CW = BB + 3;
  localparam int AW = BB + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          iorq_b = 1'b1, mreq_b = 1'b1, rfsh_b = 1'b1, wr_b = 1'b1, rd_b = 1'b1;
  logic [7:0]    adr_hi = 8'h00, data = 8'h00;
  logic [AW-1:0] ramadrhi;
  logic          ramcs_b, ramwe_b, ramoe_b, ramdis;
  logic [CW-1:0] cfg_q;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  cpc_ram_bank_ctrl #(.BANK_BITS(BB)) dut (
    .clk(clk), .reset(reset), .iorq_b(iorq_b), .mreq_b(mreq_b), .rfsh_b(rfsh_b),
    .wr_b(wr_b), .rd_b(rd_b), .adr_hi(adr_hi), .data(data), .ramadrhi(ramadrhi),
    .ramcs_b(ramcs_b), .ramwe_b(ramwe_b), .ramoe_b(ramoe_b), .ramdis(ramdis), .cfg_q(cfg_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Which expansion block a CPU block lands in for a mode, or -1 if not in expansion SRAM.
  function automatic int map_blk(input int m, input int b);
    if (m == 2) return b;
    if ((m == 1 || m == 3) && b == 3) return 3;
    if (m >= 4 && b == 1) return m - 4;
    return -1;
  endfunction

  function automatic bit io_hit(input logic [7:0] a, input logic [7:0] d);
    bit ok;
    ok = (a[7] == 1'b0) && (d[7:6] == 2'b11);
`ifdef CPC_EXT_BANK_EN
    if (BB < 6 && a[5]) ok = 1'b0;
`endif
    return ok;
  endfunction

  function automatic logic [CW-1:0] io_cfg(input logic [7:0] a, input logic [7:0] d);
    int bank;
    bank = int'(d[5:3]);
`ifdef CPC_EXT_BANK_EN
    bank = bank + (int'(~a[BB-4:0]) * 8);
`endif
    return CW'(bank * 8 + int'(d[2:0]));
  endfunction

  logic [CW-1:0] m_cfg, m_pend_cfg;
  bit            m_pend, m_io_done, m_in_mem;
  int            m_blk;
  logic [AW-1:0] e_adr;
  bit            e_cs, e_we, e_oe, e_dis;

  always @(posedge clk) begin
    int eb;
    if (reset) begin
      m_cfg = '0; m_pend_cfg = '0; m_pend = 0; m_io_done = 0; m_in_mem = 0; m_blk = 0;
      e_cs = 1; e_we = 1; e_oe = 1; e_dis = 0; e_adr = '0;
    end else begin
      eb = (m_in_mem && !mreq_b) ? map_blk(int'(m_cfg[2:0]), m_blk) : -1;
      e_cs  = (eb < 0);
      e_dis = (eb >= 0);
      e_adr = (eb >= 0) ? {m_cfg[CW-1:3], 2'(eb)} : '0;
      e_we  = !(eb >= 0 && !wr_b);
      e_oe  = !(eb >= 0 && !rd_b);
      if (!m_in_mem && m_pend) begin
        m_cfg  = m_pend_cfg;
        m_pend = 0;
      end
      if (iorq_b) m_io_done = 0;
      else if (!m_io_done && !wr_b && io_hit(adr_hi, data)) begin
        m_pend_cfg = io_cfg(adr_hi, data);
        m_pend     = 1;
        m_io_done  = 1;
      end
      if (m_in_mem) begin
        if (mreq_b) m_in_mem = 0;
      end else if (!mreq_b && rfsh_b) begin
        m_in_mem = 1;
        m_blk    = int'(adr_hi[7:6]);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_ramcs_b", ramcs_b, e_cs);
      check("cmp_ramdis", ramdis, e_dis);
      check("cmp_ramwe_b", ramwe_b, e_we);
      check("cmp_ramoe_b", ramoe_b, e_oe);
      check("cmp_ramadrhi", ramadrhi, e_adr);
      check("cmp_cfg_q", cfg_q, m_cfg);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d, input int n);
    adr_hi = a; data = d; iorq_b = 0; wr_b = 0;
    repeat (n) tick();
    iorq_b = 1; wr_b = 1;
    tick(); tick();
  endtask

  task automatic mem_rd(input logic [7:0] a, output logic cs, output logic dis,
                        output logic [AW-1:0] adr);
    adr_hi = a; mreq_b = 0; rd_b = 0; rfsh_b = 1;
    tick(); tick();
    cs = ramcs_b; dis = ramdis; adr = ramadrhi;
    tick();
    mreq_b = 1; rd_b = 1;
    tick(); tick();
  endtask

  task automatic mem_cyc(input logic [7:0] a, input bit is_wr, input int n);
    adr_hi = a; mreq_b = 0; rfsh_b = 1;
    if (is_wr) wr_b = 0; else rd_b = 0;
    repeat (n) tick();
    mreq_b = 1; rd_b = 1; wr_b = 1;
    tick();
  endtask

  task automatic refresh(input int n);
    adr_hi = 8'($urandom); mreq_b = 0; rfsh_b = 0;
    repeat (n) tick();
    mreq_b = 1; rfsh_b = 1;
    tick();
  endtask

  // IO write issued while a memory cycle is already active
  task automatic overlap(input logic [7:0] am, input logic [7:0] aio, input logic [7:0] d);
    adr_hi = am; mreq_b = 0; rd_b = 0;
    tick();
    adr_hi = aio; data = d; iorq_b = 0; wr_b = 0;
    tick(); tick();
    iorq_b = 1; wr_b = 1; mreq_b = 1; rd_b = 1;
    tick(); tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic          cs, dis;
    logic [AW-1:0] adr;

    reset = 1;
    tick();
    chk_en = 1;
    tick();
    check("reset_ramcs_b", ramcs_b, 1'b1);
    check("reset_ramwe_b", ramwe_b, 1'b1);
    check("reset_ramoe_b", ramoe_b, 1'b1);
    check("reset_ramdis", ramdis, 1'b0);
    check("reset_ramadrhi", ramadrhi, 8'h00);
    check("reset_cfg_q", cfg_q, 9'h000);
    reset = 0;
    tick();

    // 1: mode 2, read block 1
    io_write(8'h7F, 8'hC2, 2);
    tick();
    check("t1_cfg_q", cfg_q, 9'h002);
    mem_rd(8'h40, cs, dis, adr);
    check("t1_ramcs_b", cs, 1'b0);
    check("t1_ramdis", dis, 1'b1);
    check("t1_ramadrhi", adr, 8'h01);

    // 2: long IORQ, mode 5
    io_write(8'h7F, 8'hC5, 5);
    check("t2_cfg_q", cfg_q, 9'h005);
    mem_rd(8'h80, cs, dis, adr);
    check("t2_blk2_ramcs_b", cs, 1'b1);
    check("t2_blk2_ramdis", dis, 1'b0);
    mem_rd(8'h40, cs, dis, adr);
    check("t2_blk1_ramcs_b", cs, 1'b0);
    check("t2_blk1_ramadrhi", adr, 8'h01);

    // 3: config write during an active cycle does not change its mapping
    adr_hi = 8'hC0; mreq_b = 0; rd_b = 0;
    tick();
    adr_hi = 8'h7F; data = 8'hC1; iorq_b = 0; wr_b = 0;
    tick();
    check("t3_hold_ramcs_b", ramcs_b, 1'b1);
    tick();
    check("t3_hold_ramcs_b2", ramcs_b, 1'b1);
    check("t3_hold_cfg_q", cfg_q, 9'h005);
    iorq_b = 1; wr_b = 1; mreq_b = 1; rd_b = 1;
    tick(); tick(); tick();
    check("t3_new_cfg_q", cfg_q, 9'h001);
    mem_rd(8'hC0, cs, dis, adr);
    check("t3_new_ramcs_b", cs, 1'b0);
    check("t3_new_ramadrhi", adr, 8'h03);

    // 4: refresh under mode 2
    io_write(8'h7F, 8'hC2, 2);
    adr_hi = 8'h40; mreq_b = 0; rfsh_b = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_rfsh_ramcs_b", ramcs_b, 1'b1);
      check("t4_rfsh_ramdis", ramdis, 1'b0);
    end
    mreq_b = 1; rfsh_b = 1;
    tick();

    // 5: upper bank bits
    io_write(8'h78, 8'hFC, 2);
    mem_rd(8'h40, cs, dis, adr);
    check("t5_ramcs_b", cs, 1'b0);
`ifdef CPC_EXT_BANK_EN
    check("t5_ramadrhi", adr, 8'hFC);
    check("t5_cfg_q", cfg_q, 9'h1FC);
`else
    check("t5_ramadrhi", adr, 8'h1C);
    check("t5_cfg_q", cfg_q, 9'h03C);
`endif

    // 6: reset in the middle of an active mapped cycle
    io_write(8'h7F, 8'hC2, 2);
    adr_hi = 8'h00; mreq_b = 0; rd_b = 0;
    tick(); tick();
    check("t6_pre_ramcs_b", ramcs_b, 1'b0);
    reset = 1;
    tick();
    check("t6_rst_ramcs_b", ramcs_b, 1'b1);
    check("t6_rst_ramdis", ramdis, 1'b0);
    check("t6_rst_cfg_q", cfg_q, 9'h000);
    reset = 0; mreq_b = 1; rd_b = 1;
    tick(); tick();

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      int op;
      logic [7:0] a, d;
      op = $urandom_range(0, 19);
      a  = ($urandom_range(0, 1) != 0) ? 8'h7F : 8'($urandom);
      d  = ($urandom_range(0, 2) != 0) ? {2'b11, 6'($urandom)} : 8'($urandom);
      if (op < 6)       io_write(a, d, $urandom_range(1, 5));
      else if (op < 13) mem_cyc(8'($urandom), $urandom_range(0, 1) != 0, $urandom_range(2, 5));
      else if (op < 15) refresh($urandom_range(1, 3));
      else if (op < 18) overlap(8'($urandom), a, d);
      else if (op < 19) tick();
      else begin
        reset = 1;
        tick();
        reset = 0;
        tick();
      end
    end

    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
